psum_acc_requant: RTL and testbench

Post-MAC partial-sum accumulator and requantizer. It sits directly downstream of the 16-lane signed MAC stage (`mac_b16_s16`) and consumes its registered 36-bit dot-product partial sum. It accumulates a programmable-length run of partials into a wide accumulator, then rounds, shifts and saturates the result to signed 16 bits. Results are buffered in a 2-entry output FIFO behind a ready/valid handshake. The MAC cannot stall, so loss of a result is reported through a sticky error flag and is never silent.

---
 rtl/psum_acc_requant_if.sv | 26 ++
 rtl/psum_acc_requant.sv | 127 ++++++++++++
 tb/tb_psum_acc_requant.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_requant_if.sv
// Partial-sum input stream and requantized result stream of psum_acc_requant.
// master = producer/consumer side (MAC + downstream), slave = the accumulator.
interface psum_acc_requant_if #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16,
  parameter int SH_W  = 6
);
  logic             psum_valid;
  logic [IN_W-1:0]  psum;
  logic             psum_last;
  logic [SH_W-1:0]  shift;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output psum_valid, psum, psum_last, shift, out_ready,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  psum_valid, psum, psum_last, shift, out_ready,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/psum_acc_requant.sv
// Accumulates runs of MAC partial sums, then rounds/shifts/saturates each run
// to OUT_W bits and queues the result in a 2-entry ready/valid FIFO.
//
// state | meaning
// IDLE  | no run open; next non-last beat starts a run
// ACCUM | run open; acc holds the running sum
module psum_acc_requant #(
  parameter int IN_W  = 36,
  parameter int ACC_W = 48,
  parameter int OUT_W = 16,
  parameter int SH_W  = 6
) (
  input  logic        clk,
  input  logic        rstn,
  psum_acc_requant_if.slave bus,
  output logic        ovf_err,
  output logic [11:0] beat_cnt
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] psum_sx;
  logic [ACC_W-1:0] acc_nxt;

  logic             s1_valid;
  logic [ACC_W-1:0] s1_sum;
  logic [SH_W-1:0]  s1_shift;

  assign psum_sx = {{(ACC_W-IN_W){bus.psum[IN_W-1]}}, bus.psum};
  assign acc_nxt = (state == IDLE) ? psum_sx : acc + psum_sx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_shift <= '0;
    end else begin
      s1_valid <= bus.psum_valid & bus.psum_last;
      if (bus.psum_valid) begin
        if (bus.psum_last) begin
          s1_sum   <= acc_nxt;
          s1_shift <= bus.shift;
          state    <= IDLE;
          beat_cnt <= '0;
        end else begin
          acc   <= acc_nxt;
          state <= ACCUM;
          if (state == IDLE)
            beat_cnt <= 12'd1;
          else if (beat_cnt != 12'hFFF)
            beat_cnt <= beat_cnt + 12'd1;
        end
      end
    end
  end

  // Requantize at ACC_W+1 bits so the rounding bias can never wrap.
  logic [ACC_W:0]        rnd;
  logic [ACC_W:0]        biased;
  logic signed [ACC_W:0] r;
  logic                  sat_hi;
  logic                  sat_lo;
  logic [OUT_W-1:0]      q_data;
  logic                  q_sat;

  always_comb begin
    rnd    = {{ACC_W{1'b0}}, 1'b1} << s1_shift;
    rnd    = rnd >> 1;
    biased = {s1_sum[ACC_W-1], s1_sum} + rnd;
    r      = $signed(biased) >>> s1_shift;
    sat_hi = ~r[ACC_W] & (|r[ACC_W-1:OUT_W-1]);
    sat_lo = r[ACC_W] & ~(&r[ACC_W-1:OUT_W-1]);
    q_sat  = sat_hi | sat_lo;
    if (sat_hi)
      q_data = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo)
      q_data = {1'b1, {(OUT_W-1){1'b0}}};
    else
      q_data = r[OUT_W-1:0];
  end

  logic [OUT_W:0] mem [2];
  logic           rd_ptr;
  logic           wr_ptr;
  logic [1:0]     count;
  logic           pop;
  logic           full;
  logic           push_ok;

  assign pop     = (count != 2'd0) & bus.out_ready;
  assign full    = (count == 2'd2);
  // When full, a same-cycle pop frees exactly the slot wr_ptr points at.
  assign push_ok = s1_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {q_sat, q_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (s1_valid && !push_ok)
        ovf_err <= 1'b1;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign {bus.out_sat, bus.out_data} = mem[rd_ptr];

endmodule

// File: tb/tb_psum_acc_requant.sv
// Directed bench for psum_acc_requant: hand-computed vectors checked with
// immediate assertions; inputs change and outputs are sampled 1 ns after posedge.
module tb_psum_acc_requant;
  logic        clk = 1'b0;
  logic        rstn;
  logic        ovf_err;
  logic [11:0] beat_cnt;
  int          checks = 0;
  int          errors = 0;

  psum_acc_requant_if bus ();

  psum_acc_requant dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .ovf_err  (ovf_err),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [35:0] v, input logic last, input logic [5:0] sh);
    bus.psum_valid = 1'b1;
    bus.psum       = v;
    bus.psum_last  = last;
    bus.shift      = sh;
    tick();
    bus.psum_valid = 1'b0;
    bus.psum_last  = 1'b0;
  endtask

  initial begin
    rstn           = 1'b0;
    bus.psum_valid = 1'b0;
    bus.psum       = '0;
    bus.psum_last  = 1'b0;
    bus.shift      = '0;
    bus.out_ready  = 1'b1;
    tick(); tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    rstn = 1'b1;
    tick();

    // single beat, 2-cycle latency
    beat(36'd1000, 1'b1, 6'd0);
    chk("single_lat1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_data", 32'(bus.out_data), 32'd1000);
    chk("single_sat", 32'(bus.out_sat), 32'd0);
    tick();
    chk("single_popped", 32'(bus.out_valid), 32'd0);

    // three-beat run, (250+2)>>2 = 63
    beat(36'd100, 1'b0, 6'd2);
    chk("run_cnt1", 32'(beat_cnt), 32'd1);
    beat(36'd200, 1'b0, 6'd2);
    chk("run_cnt2", 32'(beat_cnt), 32'd2);
    beat(-36'sd50, 1'b1, 6'd2);
    chk("run_cnt0", 32'(beat_cnt), 32'd0);
    tick();
    chk("run_valid", 32'(bus.out_valid), 32'd1);
    chk("run_data", 32'(bus.out_data), 32'd63);
    tick();

    // (-6+2)>>>2 = -1
    beat(-36'sd6, 1'b1, 6'd2);
    tick();
    chk("neg_data", 32'(bus.out_data), 32'h0000_FFFF);
    chk("neg_sat", 32'(bus.out_sat), 32'd0);
    tick();

    // saturation, back-to-back single-beat runs at 1 result/cycle
    beat(36'd1048576, 1'b1, 6'd0);
    beat(-36'sd1048576, 1'b1, 6'd0);
    chk("sat_hi_data", 32'(bus.out_data), 32'h0000_7FFF);
    chk("sat_hi_flag", 32'(bus.out_sat), 32'd1);
    beat(36'd1048576, 1'b1, 6'd6);
    chk("sat_lo_data", 32'(bus.out_data), 32'h0000_8000);
    chk("sat_lo_flag", 32'(bus.out_sat), 32'd1);
    tick();
    chk("shift6_valid", 32'(bus.out_valid), 32'd1);
    chk("shift6_data", 32'(bus.out_data), 32'd16384);
    chk("shift6_sat", 32'(bus.out_sat), 32'd0);
    tick();
    chk("sat_drained", 32'(bus.out_valid), 32'd0);

    // backpressure: third result dropped
    bus.out_ready = 1'b0;
    beat(36'd1, 1'b1, 6'd0);
    beat(36'd2, 1'b1, 6'd0);
    beat(36'd3, 1'b1, 6'd0);
    chk("bp_ovf_pre", 32'(ovf_err), 32'd0);
    tick();
    chk("bp_ovf", 32'(ovf_err), 32'd1);
    chk("bp_head1", 32'(bus.out_data), 32'd1);
    tick();
    chk("bp_head1_stable", 32'(bus.out_data), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_head2", 32'(bus.out_data), 32'd2);
    chk("bp_valid2", 32'(bus.out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(ovf_err), 32'd1);

    // same sequence with a pop on the cycle result 3 arrives
    rstn = 1'b0;
    tick();
    chk("rst2_ovf", 32'(ovf_err), 32'd0);
    rstn = 1'b1;
    bus.out_ready = 1'b0;
    beat(36'd1, 1'b1, 6'd0);
    beat(36'd2, 1'b1, 6'd0);
    beat(36'd3, 1'b1, 6'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("bpp_ovf", 32'(ovf_err), 32'd0);
    chk("bpp_head2", 32'(bus.out_data), 32'd2);
    tick();
    chk("bpp_head3", 32'(bus.out_data), 32'd3);
    chk("bpp_valid3", 32'(bus.out_valid), 32'd1);
    tick();
    chk("bpp_empty", 32'(bus.out_valid), 32'd0);

    // reset mid-run; a beat during reset is ignored
    beat(36'd500, 1'b0, 6'd0);
    beat(36'd500, 1'b0, 6'd0);
    chk("mid_cnt", 32'(beat_cnt), 32'd2);
    rstn           = 1'b0;
    bus.psum_valid = 1'b1;
    bus.psum       = 36'd999;
    bus.psum_last  = 1'b1;
    tick();
    chk("mid_rst_cnt", 32'(beat_cnt), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_sat", 32'(bus.out_sat), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_err), 32'd0);
    rstn           = 1'b1;
    bus.psum_valid = 1'b0;
    bus.psum_last  = 1'b0;
    beat(36'd7, 1'b1, 6'd0);
    chk("mid_no_ghost", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mid_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_data", 32'(bus.out_data), 32'd7);
    tick();

    // beat_cnt saturation with zero partials
    for (int i = 0; i < 4100; i++) beat(36'd0, 1'b0, 6'd0);
    chk("cnt_sat", 32'(beat_cnt), 32'd4095);
    beat(36'd0, 1'b1, 6'd0);
    tick();
    chk("zero_data", 32'(bus.out_data), 32'd0);
    tick();

    // 4096 x (2^35-1) = 2^47-4096; +2^31 >> 32 = 32768 -> saturate
    for (int i = 0; i < 4095; i++) beat(36'h7_FFFF_FFFF, 1'b0, 6'd32);
    chk("wide_cnt", 32'(beat_cnt), 32'd4095);
    beat(36'h7_FFFF_FFFF, 1'b1, 6'd32);
    tick();
    chk("wide_valid", 32'(bus.out_valid), 32'd1);
    chk("wide_data", 32'(bus.out_data), 32'h0000_7FFF);
    chk("wide_sat", 32'(bus.out_sat), 32'd1);
    tick();

    // same sum, shift 40: (2^47-4096+2^39)>>40 = 128
    for (int i = 0; i < 4095; i++) beat(36'h7_FFFF_FFFF, 1'b0, 6'd40);
    beat(36'h7_FFFF_FFFF, 1'b1, 6'd40);
    tick();
    chk("wide40_data", 32'(bus.out_data), 32'd128);
    chk("wide40_sat", 32'(bus.out_sat), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
